// File: rtl/mem_bus_loader_if.sv
// rtl/mem_bus_loader_if.sv - byte streams and memory bus seen by the loader
interface mem_bus_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] mem_addr;
  logic        mem_wr_ena;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  modport master (
    input  rx_data, rx_valid, tx_ready, mem_rd_data,
    output rx_ready, tx_data, tx_valid, mem_addr, mem_wr_ena, mem_wr_data
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, mem_rd_data,
    input  rx_ready, tx_data, tx_valid, mem_addr, mem_wr_ena, mem_wr_data
  );
endinterface

// File: rtl/mem_bus_loader.sv
// rtl/mem_bus_loader.sv - UART byte-stream driven memory bus initiator
module mem_bus_loader #(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 1_200_000,
  parameter bit HOLD_AT_RESET  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_loader_if.master bus,
  output logic             core_hold_o,
  output logic             busy_o
);
  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_G = 8'h47;
  localparam logic [7:0] OP_H = 8'h48;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, WRITE, READ_WAIT, RESP, RESP_READ
  } state_t;

  state_t      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [TW-1:0] to_q, to_d;
  logic [31:0] addr_sh_q, addr_sh_d;
  logic [31:0] data_sh_q, data_sh_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wr_data_q, mem_wr_data_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        rx_ready_q, rx_ready_d;
  logic        hold_q, hold_d;
  logic        rx_fire, tx_fire;

  assign rx_fire = rx_ready_q & bus.rx_valid;
  assign tx_fire = tx_valid_q & bus.tx_ready;

  always_comb begin
    state_d       = state_q;
    is_wr_d       = is_wr_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    lat_d         = lat_q;
    to_d          = to_q;
    addr_sh_d     = addr_sh_q;
    data_sh_d     = data_sh_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    rdata_d       = rdata_q;
    tx_data_d     = tx_data_q;
    hold_d        = hold_q;
    case (state_q)
      IDLE: if (rx_fire) begin
        to_d  = '0;
        cnt_d = 2'd0;
        case (bus.rx_data)
          OP_W:    begin is_wr_d = 1'b1; state_d = ADDR; end
          OP_R:    begin is_wr_d = 1'b0; state_d = ADDR; end
          OP_G:    begin hold_d = 1'b0; tx_data_d = ACK; state_d = RESP; end
          OP_H:    begin hold_d = 1'b1; tx_data_d = ACK; state_d = RESP; end
          default: begin tx_data_d = NAK; state_d = RESP; end
        endcase
      end
      ADDR: if (rx_fire) begin
        to_d = '0;
        cnt_d = cnt_q + 2'd1;
        addr_sh_d[{cnt_q, 3'b000} +: 8] = bus.rx_data;
        if (cnt_q == 2'd3) begin
          if (is_wr_q) begin
            state_d = DATA;
          end else if (hold_q) begin
            mem_addr_d = addr_sh_d;
            lat_d      = '0;
            state_d    = READ_WAIT;
          end else begin
            tx_data_d = NAK;
            state_d   = RESP;
          end
        end
      end else if (to_q == TO_LAST) begin
        to_d = '0;
        state_d = IDLE;
      end else begin
        to_d = to_q + 1'b1;
      end
      DATA: if (rx_fire) begin
        to_d = '0;
        cnt_d = cnt_q + 2'd1;
        data_sh_d[{cnt_q, 3'b000} +: 8] = bus.rx_data;
        if (cnt_q == 2'd3) begin
          // Bus registers load only when the write really happens.
          if (hold_q) begin
            mem_addr_d    = addr_sh_q;
            mem_wr_data_d = data_sh_d;
            state_d       = WRITE;
          end else begin
            tx_data_d = NAK;
            state_d   = RESP;
          end
        end
      end else if (to_q == TO_LAST) begin
        to_d = '0;
        state_d = IDLE;
      end else begin
        to_d = to_q + 1'b1;
      end
      WRITE: begin
        tx_data_d = ACK;
        state_d   = RESP;
      end
      READ_WAIT: if (lat_q == LAT_LAST) begin
        rdata_d   = bus.mem_rd_data;
        tx_data_d = bus.mem_rd_data[7:0];
        idx_d     = 2'd0;
        state_d   = RESP_READ;
      end else begin
        lat_d = lat_q + 1'b1;
      end
      RESP: if (tx_fire) state_d = IDLE;
      RESP_READ: if (tx_fire) begin
        if (idx_q == 2'd3) begin
          state_d = IDLE;
        end else begin
          idx_d     = idx_q + 2'd1;
          tx_data_d = rdata_q[{idx_d, 3'b000} +: 8];
        end
      end
      default: state_d = IDLE;
    endcase
    rx_ready_d = (state_d == IDLE) || (state_d == ADDR) || (state_d == DATA);
    tx_valid_d = (state_d == RESP) || (state_d == RESP_READ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      is_wr_q       <= 1'b0;
      cnt_q         <= 2'd0;
      idx_q         <= 2'd0;
      lat_q         <= '0;
      to_q          <= '0;
      addr_sh_q     <= '0;
      data_sh_q     <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      rdata_q       <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      rx_ready_q    <= 1'b0;
      hold_q        <= HOLD_AT_RESET;
    end else begin
      state_q       <= state_d;
      is_wr_q       <= is_wr_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      lat_q         <= lat_d;
      to_q          <= to_d;
      addr_sh_q     <= addr_sh_d;
      data_sh_q     <= data_sh_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rdata_q       <= rdata_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      rx_ready_q    <= rx_ready_d;
      hold_q        <= hold_d;
    end
  end

  assign bus.rx_ready    = rx_ready_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.mem_wr_ena  = (state_q == WRITE);
  assign core_hold_o     = hold_q;
  assign busy_o          = (state_q != IDLE);
endmodule

// File: doc/mem_bus_loader.md
Name: mem_bus_loader

Overview:
- Byte-stream-driven memory bus initiator. It drives the same address, write-enable, write-data and read-data interface the core uses toward the MMU, so the MMU sees it as a second initiator.
- A system-level mux selects between the loader and the core. While `core_hold` is high, the core is held in reset and the loader owns the bus.
- Used to load and inspect instruction/data memory from a UART (byte valid/ready streams) without rebuilding the bitstream.

Parameters:
- `READ_LATENCY`, 1: cycles from `mem_addr` valid to `mem_rd_data` valid (MMU reads are synchronous).
- `TIMEOUT_CYCLES`, 1_200_000: idle cycles allowed between bytes of one frame before the frame is abandoned (100 ms at 12 MHz).
- `HOLD_AT_RESET`, 1: reset value of `core_hold`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_data` in 8: command byte from the UART receiver.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts `rx_data` this cycle.
- `tx_data` out 8: response byte to the UART transmitter.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: transmitter accepts `tx_data` this cycle.
- `mem_addr` out 32: bus address.
- `mem_wr_ena` out 1: bus write strobe.
- `mem_wr_data` out 32: bus write data.
- `mem_rd_data` in 32: bus read data.
- `core_hold` out 1: 1 means the core is held in reset and the bus is granted to the loader.
- `busy` out 1: high in any state other than IDLE.

Behaviour:
- One clock (`clk`). Reset is asynchronous and active-high (`rst`). Reset mid-frame aborts everything.
- Reset values:
  - state = IDLE, `rx_ready` = 0, `tx_valid` = 0, `tx_data` = 0.
  - `mem_addr` = 0, `mem_wr_data` = 0, `mem_wr_ena` = 0, `busy` = 0.
  - `core_hold` = `HOLD_AT_RESET`.
- Handshakes:
  - A byte transfers when valid and ready are both high on a rising edge.
  - `rx_ready` is high only in IDLE, ADDR and DATA. `rx_valid` in any other state is left pending, never dropped.
  - While `tx_valid` is high, `tx_data` is stable until `tx_ready`.
- Frame format:
  - One opcode byte, then operands, all least-significant byte first.
  - 0x57 'W': 4 address bytes + 4 data bytes.
  - 0x52 'R': 4 address bytes.
  - 0x47 'G': no operands.
  - 0x48 'H': no operands.
- Per-opcode responses:
  - 'W' writes one 32-bit word, then sends 0x06 (ACK).
  - 'R' reads one word, then sends its 4 bytes LSB first. No ACK follows.
  - 'G' clears `core_hold` and sends ACK.
  - 'H' sets `core_hold` and sends ACK.
  - Any other opcode sends 0x15 (NAK).
- 'W' and 'R' received while `core_hold` = 0 send NAK with no bus activity. For 'R', the 4 address bytes are still consumed first.
- States:
  - IDLE: accept opcode and decode it.
    - 'W' or 'R': ADDR, with byte count = 0.
    - 'G' or 'H': RESP(ACK).
    - Unknown: RESP(NAK).
  - ADDR: shift bytes into the address register at `byte_count*8`. On the 4th byte: 'W' goes to DATA, 'R' goes to READ_WAIT.
  - DATA: shift bytes into the data register. On the 4th byte, go to WRITE.
  - WRITE: exactly one cycle with `mem_wr_ena` = 1 and `mem_addr`/`mem_wr_data` driven. Then RESP(ACK).
  - READ_WAIT: hold `mem_addr` for `READ_LATENCY` cycles. Capture `mem_rd_data` at the last of these edges, then go to RESP_READ with index = 0.
  - RESP: hold `tx_valid` with the ACK/NAK byte; on handshake go to IDLE.
  - RESP_READ: send `captured[8*idx +: 8]`. On the handshake with idx = 3, go to IDLE.
- Timing:
  - Write: last data byte handshake at edge N; `mem_wr_ena` high during cycle N+1; ACK `tx_valid` high from cycle N+2.
  - Read: last address byte at edge N; data captured at edge N+`READ_LATENCY`; first `tx_valid` on the following cycle.
- Bus outputs:
  - `mem_addr` and `mem_wr_data` are registered and keep their last value outside transactions.
  - `mem_wr_ena` is 0 in every state except WRITE.
- Timeout:
  - A counter resets on every accepted byte and increments in ADDR and DATA.
  - Reaching `TIMEOUT_CYCLES` returns to IDLE with no response and no bus write.
  - The counter is frozen in all other states.
- Address bits pass unmodified; alignment is the MMU's job.

Test Plan:
- Reset with `HOLD_AT_RESET`=1 → `core_hold`=1, `rx_ready`=0 for the reset cycle and 1 afterwards, `tx_valid`=0, `mem_wr_ena`=0.
- Send 57 00 10 00 00 EF BE AD DE → exactly one cycle with `mem_wr_ena`=1, `mem_addr`=0x00001000, `mem_wr_data`=0xDEADBEEF; then `tx_data`=0x06.
- Model memory returns 0xDEADBEEF at 0x1000 with 1-cycle latency; send 52 00 10 00 00 → `tx_data` sequence EF, BE, AD, DE. Hold `tx_ready`=0 for 5 cycles mid-sequence → bytes stay stable, none lost.
- Send 47 → ACK and `core_hold`=0. Then 57 plus 8 operand bytes → NAK, `mem_wr_ena` never asserted. Then 48 → ACK and `core_hold`=1.
- Send 57 00 10, wait `TIMEOUT_CYCLES`+2 cycles, then send 99 → the abandoned frame produces no response and no write; 0x99 produces NAK.
- Assert `rst` during WRITE and during RESP_READ → outputs return to reset values immediately, and the next frame completes normally.
